// File: rtl/dpram_pkg.sv
// Shared sizing for the 16x8 dual-port RAM and its FIFO controller.
package dpram_pkg;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  typedef logic [AW:0] ptr_t;
endpackage

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller in front of a 1-cycle-latency dual-port RAM.
// The RAM's r_data register acts as the output stage, giving DEPTH+1 words of storage.
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int DW           = dpram_pkg::DW,
  parameter int AW           = dpram_pkg::AW,
  parameter int AFULL_THRESH = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          ram_enb,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW:0]   ram_w_addr,
  output logic [AW:0]   ram_r_addr,
  output logic [DW-1:0] ram_w_data,
  input  logic [DW-1:0] ram_r_data
);

  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        ov;
  logic        ram_empty;
  logic        ram_full;

  // Extra wrap bit distinguishes full (MSB differs, index equal) from empty.
  assign ram_empty = (wp == rp);
  assign ram_full  = ((wp ^ rp) == {1'b1, {AW{1'b0}}});

  // in_ready depends only on state and flush, never on out_ready.
  assign in_ready = !ram_full && !flush;
  assign ram_wr   = in_valid && in_ready && !rst;

  // Refill r_data whenever it is empty or being consumed this cycle.
  assign ram_rd   = !ram_empty && !flush && (!ov || out_ready) && !rst;
  assign ram_enb  = ram_wr || ram_rd;

  assign ram_w_addr = wp;
  assign ram_r_addr = rp;
  assign ram_w_data = in_data;

  assign out_valid   = ov;
  assign out_data    = ram_r_data;
  assign level       = (wp - rp) + {{AW{1'b0}}, ov};
  assign almost_full = (level >= (AW+1)'(AFULL_THRESH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      ov <= 1'b0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      ov <= 1'b0;
    end else begin
      if (ram_wr) wp <= wp + 1'b1;
      if (ram_rd) rp <= rp + 1'b1;
      ov <= ram_rd ? 1'b1 : (ov && !out_ready);
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural 16x8 RAM and a queue-based FIFO reference.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid, almost_full;
  logic       ram_enb, ram_wr, ram_rd;
  logic [7:0] out_data, ram_w_data;
  logic [7:0] ram_r_data;
  logic [4:0] level, ram_w_addr, ram_r_addr;

  logic [7:0] mem [16];
  logic [7:0] q [$];
  int nrun = 0;
  int nfail = 0;
  int drained = 0;

  always #5 clk = ~clk;

  // RAM: write and read registered, r_data held while rd=0.
  always @(posedge clk) begin
    if (ram_enb) begin
      if (ram_wr) mem[ram_w_addr[3:0]] <= ram_w_data;
      if (ram_rd) ram_r_data <= mem[ram_r_addr[3:0]];
    end
  end

  dpram_fifo_ctrl #(.DW(8), .AW(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full),
    .ram_enb(ram_enb), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic; the queue q is the ideal FIFO content (accepted minus consumed).
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, output logic acc);
    logic cons;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    if (fl) begin
      chk("flush_in_ready", in_ready, 0);
      chk("flush_wr", ram_wr, 0);
      chk("flush_rd", ram_rd, 0);
    end else if (q.size() == 17) chk("full_in_ready", in_ready, 0);
    else if (q.size() < 16) chk("in_ready", in_ready, 1);
    if (out_valid) begin
      if (q.size() == 0) chk("valid_when_empty", out_valid, 0);
      else chk("out_data", out_data, q[0]);
    end
    chk("enb", ram_enb, ram_wr | ram_rd);
    acc  = in_valid & in_ready;
    cons = out_valid & out_ready;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (cons) begin void'(q.pop_front()); drained++; end
      if (acc) q.push_back(d);
    end
    chk("level", level, q.size());
    chk("almost_full", almost_full, (q.size() >= 12) ? 1 : 0);
  endtask

  initial begin
    logic a;
    int n, guard, first, sent;
    logic [7:0] held;

    // Reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr", ram_wr, 0);
    chk("rst_rd", ram_rd, 0);
    @(negedge clk) rst = 1'b0;

    // Fill to 17 words with the consumer stalled
    n = 0; guard = 0;
    while (n < 17 && guard < 40) begin
      cycle(1'b1, 8'(n + 1), 1'b0, 1'b0, a);
      if (a) n++;
      guard++;
    end
    chk("fill_count", n, 17);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, a);
    chk("fill_extra_rejected", a, 0);
    chk("fill_level", level, 17);
    chk("fill_afull", almost_full, 1);
    drained = 0;
    repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("drain_count", drained, 17);

    // Streaming 40 words; pointers wrap past 31
    drained = 0; sent = 0; first = -1;
    for (int c = 0; c < 50; c++) begin
      cycle(sent < 40, 8'(sent), 1'b1, 1'b0, a);
      if (a) sent++;
      if (drained > 0 && first < 0) first = c;
    end
    chk("stream_sent", sent, 40);
    chk("stream_drained", drained, 40);
    chk("stream_latency", first, 2);

    // Backpressure with level 6
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, a);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
    chk("bp_valid", out_valid, 1);
    held = out_data;
    repeat (5) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, a);
      chk("bp_stable", out_data, held);
      chk("bp_rd", ram_rd, 0);
      chk("bp_level", level, 6);
    end
    repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0, a);

    // Flush with a concurrent write request
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, a);
    chk("pre_flush_level", level, 9);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1, a);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_flush_level", level, 0);
    chk("post_flush_valid", out_valid, 0);
    chk("post_flush_in_ready", in_ready, 1);
    drained = 0;
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0, a);
    chk("post_flush_drained", drained, 0);

    // Randomized traffic including occasional flushes
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0, a);

    // Asynchronous reset between edges
    repeat (8) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, a);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk) rst = 1'b0;

    for (int c = 0; c < 150; c++)
      cycle($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 3) != 0, 1'b0, a);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
